// File: rtl/xlconstant_capture.sv
// xlconstant_capture: qualifies a nominally static bus and commits a value
// once it has been seen on the sampled bus for enough consecutive cycles.
// A commit updates dout, pulses change_stb and raises a single-entry
// valid/ready update port; overwriting a pending update sets the sticky ovr.
//
// A value first captured into s at edge E commits at edge E+STABLE_CYCLES-1:
// the capture edge, then STABLE_CYCLES-1 consecutive matching evaluations.
//
// Optional build macro: XLCONSTANT_CAPTURE_SYNC_EN inserts a 2-flop
// synchronizer ahead of s for a din that is asynchronous to clk.
//
// state | meaning
// INIT  | nothing committed yet; first stable value commits, even RESET_VAL
// IDLE  | s matches dout, nothing under test
// QUAL  | a value different from dout is being qualified in cand
module xlconstant_capture #(
   parameter int                    DATA_WIDTH    = 1,
   parameter int                    STABLE_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  change_stb,
   output logic [DATA_WIDTH-1:0] upd_data,
   output logic                  upd_valid,
   input  logic                  upd_ready,
   output logic                  ovr,
   input  logic                  ovr_clr,
   output logic [7:0]            glitch_cnt
);

   localparam int         CW   = $clog2(STABLE_CYCLES);
   localparam logic [8:0] TERM = 9'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_QUAL} state_t;

   state_t                state, state_d;
   logic [DATA_WIDTH-1:0] s_src, s, cand, cand_d;
   logic [CW-1:0]         cnt, cnt_d;
   logic [8:0]            run;
   logic                  commit, glitch, ovr_set;

`ifdef XLCONSTANT_CAPTURE_SYNC_EN
   logic [DATA_WIDTH-1:0] sync1, sync2;

   // two-flop synchronizer for an asynchronous din
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RESET_VAL;
         sync2 <= RESET_VAL;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   assign s_src = sync2;
`else
   assign s_src = din;
`endif

   // next run length: extends while s keeps matching the candidate
   assign run     = (s == cand) ? 9'(cnt) + 9'd1 : 9'd1;
   assign ovr_set = commit & upd_valid & ~upd_ready;

   // qualification decisions for this edge
   always_comb begin
      state_d = state;
      cand_d  = cand;
      cnt_d   = cnt;
      commit  = 1'b0;
      glitch  = 1'b0;
      case (state)
         ST_INIT: begin
            cand_d = s;
            cnt_d  = CW'(run);
            if (run == TERM) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (s != dout) begin
               cand_d = s;
               cnt_d  = CW'(1);
               if (TERM == 9'd1) commit  = 1'b1;
               else              state_d = ST_QUAL;
            end
         end
         ST_QUAL: begin
            if (s == dout) begin
               glitch  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               glitch = (s != cand);
               cand_d = s;
               cnt_d  = CW'(run);
               if (run == TERM) begin
                  commit  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            cand_d  = RESET_VAL;
            cnt_d   = '0;
         end
      endcase
   end

   // sample register, FSM state and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s          <= RESET_VAL;
         state      <= ST_INIT;
         cand       <= RESET_VAL;
         cnt        <= '0;
         dout       <= RESET_VAL;
         dout_valid <= 1'b0;
         change_stb <= 1'b0;
         upd_valid  <= 1'b0;
         ovr        <= 1'b0;
         glitch_cnt <= 8'd0;
      end else begin
         s          <= s_src;
         state      <= state_d;
         cand       <= cand_d;
         cnt        <= cnt_d;
         change_stb <= commit;
         if (commit) begin
            dout       <= cand_d;
            dout_valid <= 1'b1;
            upd_valid  <= 1'b1;
         end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
         end
         ovr <= ovr_set | (ovr & ~ovr_clr);
         if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
      end
   end

   // the pending update value is always the committed value
   assign upd_data = dout;

endmodule

// File: tb/tb_xlconstant_capture.sv
module tb_xlconstant_capture;

   localparam int         DW = 8;
   localparam int         SC = 4;
   localparam logic [7:0] RV = 8'h00;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic [DW-1:0] dout, upd_data;
   logic          dout_valid, change_stb, upd_valid, upd_ready, ovr, ovr_clr;
   logic [7:0]    glitch_cnt;

   int checks   = 0;
   int failures = 0;

   xlconstant_capture #(
      .DATA_WIDTH   (DW),
      .STABLE_CYCLES(SC),
      .RESET_VAL    (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout),
      .dout_valid(dout_valid),
      .change_stb(change_stb),
      .upd_data  (upd_data),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .ovr       (ovr),
      .ovr_clr   (ovr_clr),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: run length of identical sampled values decides commits.
   logic [7:0] m_s, m_prev, m_dout, m_v;
   int         m_run, m_gc;
   bit         m_first, m_init, m_valid, m_stb, m_uv, m_ovr;
   bit         m_commit, m_glitch, m_ovset;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s = RV; m_prev = RV; m_dout = RV; m_run = 0; m_gc = 0;
         m_first = 1; m_init = 1; m_valid = 0; m_stb = 0; m_uv = 0; m_ovr = 0;
      end else begin
         m_v = m_s;
         if (m_first || m_v != m_prev) m_run = 1;
         else                          m_run = m_run + 1;
         m_commit = (m_init || m_v != m_dout) && (m_run == SC - 1);
         m_glitch = !m_init && !m_first && (m_v != m_prev) && (m_prev != m_dout);
         m_ovset  = m_commit && m_uv && !upd_ready;
         if (m_commit) begin
            m_dout = m_v; m_valid = 1; m_uv = 1; m_init = 0;
         end else if (m_uv && upd_ready) begin
            m_uv = 0;
         end
         if (m_ovset)      m_ovr = 1;
         else if (ovr_clr) m_ovr = 0;
         if (m_glitch && m_gc < 255) m_gc = m_gc + 1;
         m_stb   = m_commit;
         m_prev  = m_v;
         m_first = 0;
         m_s     = din;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("dout",       32'(dout),       32'(m_dout));
         chk("upd_data",   32'(upd_data),   32'(m_dout));
         chk("dout_valid", 32'(dout_valid), 32'(m_valid));
         chk("change_stb", 32'(change_stb), 32'(m_stb));
         chk("upd_valid",  32'(upd_valid),  32'(m_uv));
         chk("ovr",        32'(ovr),        32'(m_ovr));
         chk("glitch_cnt", 32'(glitch_cnt), 32'(m_gc));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dout"},  32'(dout),       32'h0);
      chk({tag, "_udata"}, 32'(upd_data),   32'h0);
      chk({tag, "_dval"},  32'(dout_valid), 32'h0);
      chk({tag, "_stb"},   32'(change_stb), 32'h0);
      chk({tag, "_uv"},    32'(upd_valid),  32'h0);
      chk({tag, "_ovr"},   32'(ovr),        32'h0);
      chk({tag, "_gc"},    32'(glitch_cnt), 32'h0);
   endtask

   int hold;

   initial begin
      rst = 1'b1; din = 8'hA5; upd_ready = 1'b0; ovr_clr = 1'b0;
      step(3);
      chk_reset_vals("rst0");
      rst = 1'b0;

      // initial commit four edges after release
      step(3);
      chk("init_early_dval", 32'(dout_valid), 32'h0);
      step(1);
      chk("init_dout", 32'(dout),       32'hA5);
      chk("init_stb",  32'(change_stb), 32'h1);
      chk("init_uv",   32'(upd_valid),  32'h1);
      step(1);
      chk("init_stb_off", 32'(change_stb), 32'h0);

      // short excursion rejected
      din = 8'h3C; step(2);
      din = 8'hA5; step(5);
      chk("glitch_dout", 32'(dout),       32'hA5);
      chk("glitch_cnt1", 32'(glitch_cnt), 32'h1);

      // candidate replaced mid-qualification
      din = 8'h01; step(2);
      din = 8'h02; step(2);
      chk("repl_gc", 32'(glitch_cnt), 32'h2);
      step(1);
      chk("repl_dout_early", 32'(dout), 32'hA5);
      step(1);
      chk("repl_dout", 32'(dout),       32'h02);
      chk("repl_stb",  32'(change_stb), 32'h1);
      chk("repl_ovr",  32'(ovr),        32'h1);
      ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
      chk("clr_ovr", 32'(ovr), 32'h0);

      // overrun with consumer stalled
      din = 8'h10; step(6);
      din = 8'h20; step(6);
      chk("ovr_udata", 32'(upd_data), 32'h20);
      chk("ovr_set",   32'(ovr),      32'h1);
      upd_ready = 1'b1; step(1); upd_ready = 1'b0;
      chk("ovr_uv_drop", 32'(upd_valid), 32'h0);
      chk("ovr_sticky",  32'(ovr),       32'h1);
      ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
      chk("ovr_clr", 32'(ovr), 32'h0);

      // handshake completing on the commit edge
      din = 8'h30; step(6);
      din = 8'h40; step(3);
      upd_ready = 1'b1; step(1); upd_ready = 1'b0;
      chk("sim_uv",   32'(upd_valid), 32'h1);
      chk("sim_data", 32'(upd_data),  32'h40);
      chk("sim_ovr",  32'(ovr),       32'h0);

      // glitch counter saturation
      for (int i = 0; i < 300; i++) begin
         din = (i % 2 == 1) ? 8'h61 : 8'h62;
         step(1);
      end
      chk("gc_sat", 32'(glitch_cnt), 32'hFF);

      // reset after two qualifying cycles, then recommit
      din = 8'h55; step(3);
      rst = 1'b1; #1;
      chk_reset_vals("rst_mid");
      step(1);
      rst = 1'b0;
      step(3);
      chk("rec_early", 32'(dout_valid), 32'h0);
      step(1);
      chk("rec_dout", 32'(dout),       32'h55);
      chk("rec_stb",  32'(change_stb), 32'h1);

      // randomized traffic against the model
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 3))
               0: din = 8'hA5;
               1: din = 8'h3C;
               2: din = 8'h00;
               default: din = 8'hFF;
            endcase
            hold = $urandom_range(1, 6);
         end
         hold--;
         upd_ready = ($urandom_range(0, 3) == 0);
         ovr_clr   = ($urandom_range(0, 15) == 0);
         if (i == 1500) rst = 1'b1;
         if (i == 1502) rst = 1'b0;
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
